// File: rtl/feature_frame_loader.sv
// Collects feature bytes into a packed frame and hands complete frames to the tree
// through a one-entry output slice; short and long frames are dropped and flagged.
module feature_frame_loader #(
   parameter int NUM_FEATURES = 7,
   parameter int FEAT_W       = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [FEAT_W-1:0]              in_data,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_FEATURES*FEAT_W-1:0] out_features,
   output logic                           frame_err,
   output logic [15:0]                    frame_count
);
   localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

   typedef enum logic [1:0] {COLLECT, DISCARD, WAIT_OUT} state_t;

   state_t                              r_state;
   logic [IDX_W-1:0]                    r_idx;
   logic [NUM_FEATURES-1:0][FEAT_W-1:0] r_asm;
   logic                                r_in_ready;
   logic                                r_out_valid;
   logic [NUM_FEATURES*FEAT_W-1:0]      r_out_features;
   logic                                r_frame_err;
   logic [15:0]                         r_frame_count;

   logic                                w_accept;
   logic                                w_last_idx;
   logic                                w_out_free;
   logic [NUM_FEATURES-1:0][FEAT_W-1:0] w_frame;

   assign w_accept   = in_valid & r_in_ready;
   assign w_last_idx = (r_idx == IDX_W'(NUM_FEATURES-1));
   assign w_out_free = !r_out_valid | out_ready;

   // Completed frame as it would look with the current beat as the final feature.
   always_comb begin
      w_frame                 = r_asm;
      w_frame[NUM_FEATURES-1] = in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= COLLECT;
         r_idx          <= '0;
         r_asm          <= '0;
         r_in_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_out_features <= '0;
         r_frame_err    <= 1'b0;
         r_frame_count  <= '0;
      end else begin
         r_frame_err <= 1'b0;
         // Handshake retires the slice; a reload below in the same cycle re-arms it.
         if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
            r_frame_count <= r_frame_count + 16'd1;
         end
         case (r_state)
            COLLECT: begin
               if (w_accept) begin
                  for (int k = 0; k < NUM_FEATURES; k++)
                     if (r_idx == IDX_W'(k)) r_asm[k] <= in_data;
                  if (!w_last_idx) begin
                     if (in_last) begin
                        r_frame_err <= 1'b1;
                        r_idx       <= '0;
                     end else begin
                        r_idx <= r_idx + IDX_W'(1);
                     end
                  end else begin
                     r_idx <= '0;
                     if (!in_last) begin
                        r_state <= DISCARD;
                     end else if (w_out_free) begin
                        r_out_features <= w_frame;
                        r_out_valid    <= 1'b1;
                     end else begin
                        r_state    <= WAIT_OUT;
                        r_in_ready <= 1'b0;
                     end
                  end
               end
            end
            DISCARD: begin
               if (w_accept && in_last) begin
                  r_frame_err <= 1'b1;
                  r_state     <= COLLECT;
               end
            end
            WAIT_OUT: begin
               // Slice is full here; refill it the cycle the consumer drains it.
               if (out_ready) begin
                  r_out_features <= r_asm;
                  r_out_valid    <= 1'b1;
                  r_state        <= COLLECT;
                  r_in_ready     <= 1'b1;
               end
            end
            default: begin
               r_state    <= COLLECT;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_features = r_out_features;
   assign frame_err    = r_frame_err;
   assign frame_count  = r_frame_count;
endmodule

// File: tb/tb_feature_frame_loader.sv
// Bench for feature_frame_loader: table of frames plus hand sequences on a 7-feature
// instance, and a 1-feature instance that runs 65536 frames to wrap frame_count.
module tb_feature_frame_loader;
   localparam int NF = 7;
   localparam int FW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic            rst, in_valid, in_ready, in_last, out_valid, out_ready, frame_err;
   logic [FW-1:0]   in_data;
   logic [NF*FW-1:0] out_features;
   logic [15:0]     frame_count;

   feature_frame_loader #(.NUM_FEATURES(NF), .FEAT_W(FW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_features(out_features), .frame_err(frame_err), .frame_count(frame_count));

   // wrap instance
   logic            w_rst, w_in_valid, w_in_ready, w_in_last, w_out_valid, w_out_ready, w_frame_err;
   logic [FW-1:0]   w_in_data, w_out_features;
   logic [15:0]     w_frame_count;

   feature_frame_loader #(.NUM_FEATURES(1), .FEAT_W(FW)) u_wrap (
      .clk(clk), .rst(w_rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
      .in_last(w_in_last), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_features(w_out_features), .frame_err(w_frame_err), .frame_count(w_frame_count));

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   // scoreboards and event counters
   logic [NF*FW-1:0] sb_q[$];
   logic [FW-1:0]    wsb_q[$];
   int exp_cnt = 0;
   int hs_cnt  = 0;
   int err_cnt = 0;
   int w_hs    = 0;
   int w_err   = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) err_cnt++;
         if (out_valid && out_ready) begin
            hs_cnt++;
            chk("count_at_hs", 64'(frame_count), 64'(exp_cnt[15:0]));
            if (sb_q.size() == 0) chk("unexpected_out", 64'(1), 64'(0));
            else chk("out_features", 64'(out_features), 64'(sb_q.pop_front()));
            exp_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (!w_rst) begin
         if (w_frame_err) w_err++;
         if (w_out_valid && w_out_ready) begin
            chk("wrap_count_at_hs", 64'(w_frame_count), 64'(w_hs & 16'hFFFF));
            if (wsb_q.size() == 0) chk("wrap_unexpected_out", 64'(1), 64'(0));
            else chk("wrap_out", 64'(w_out_features), 64'(wsb_q.pop_front()));
            w_hs++;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Beat is accepted at the posedge following a negedge where in_ready was seen high.
   task automatic beat(input logic [FW-1:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin chk("in_ready_timeout", 64'(0), 64'(1)); break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 'x; in_last = 1'b0;
   endtask

   typedef struct {
      logic [15:0][FW-1:0] d;
      int                  len;
      bit                  good;
      int                  errs;
   } vec_t;

   vec_t tbl[8];

   task automatic main_test();
      logic [NF*FW-1:0] fa, fb, fy;
      logic [15:0][FW-1:0] r;
      int e0, h0;

      // reset values
      in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
      #3;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_features", 64'(out_features), 64'(0));
      chk("rst_frame_err", 64'(frame_err), 64'(0));
      chk("rst_frame_count", 64'(frame_count), 64'(0));
      idle(2); rst = 0; idle(1);

      // T1: one frame, 1-cycle latency
      for (int b = 0; b < NF; b++) begin
         if (b == NF-1) sb_q.push_back(56'h100F0E0D0C0B0A);
         beat(8'h0A + 8'(b), b == NF-1);
      end
      chk("t1_latency_valid", 64'(out_valid), 64'(1));
      chk("t1_features", 64'(out_features), 64'h100F0E0D0C0B0A);
      idle(2);
      chk("t1_frame_count", 64'(frame_count), 64'(1));
      chk("t1_valid_fell", 64'(out_valid), 64'(0));

      // T3/T4 and friends: table of frames applied with out_ready=1
      tbl[0] = '{d: '0, len: 3, good: 0, errs: 1};
      tbl[1] = '{d: '0, len: 7, good: 1, errs: 0};
      tbl[2] = '{d: '0, len: 9, good: 0, errs: 1};
      tbl[3] = '{d: '0, len: 7, good: 1, errs: 0};
      tbl[4] = '{d: '0, len: 1, good: 0, errs: 1};
      tbl[5] = '{d: '0, len: 6, good: 0, errs: 1};
      tbl[6] = '{d: '0, len: 8, good: 0, errs: 1};
      tbl[7] = '{d: '0, len: 7, good: 1, errs: 0};
      for (int k = 0; k < 8; k++) tbl[k].d = {$urandom, $urandom, $urandom, $urandom};

      for (int k = 0; k < 8; k++) begin
         e0 = err_cnt; h0 = hs_cnt;
         r = tbl[k].d;
         if (tbl[k].good) sb_q.push_back(r[NF-1:0]);
         for (int b = 0; b < tbl[k].len; b++) beat(r[b], b == tbl[k].len - 1);
         idle(3);
         chk($sformatf("vec%0d_err_pulses", k), 64'(err_cnt - e0), 64'(tbl[k].errs));
         chk($sformatf("vec%0d_outputs", k), 64'(hs_cnt - h0), 64'(tbl[k].good));
         chk($sformatf("vec%0d_count", k), 64'(frame_count), 64'(exp_cnt & 16'hFFFF));
      end

      // T2: backpressure, then seamless second frame
      out_ready = 0;
      fa = {$urandom, $urandom}; fb = {$urandom, $urandom};
      sb_q.push_back(fa); sb_q.push_back(fb);
      for (int b = 0; b < NF; b++) beat(fa[b*FW +: FW], b == NF-1);
      idle(2);
      chk("t2_a_valid", 64'(out_valid), 64'(1));
      for (int b = 0; b < NF; b++) beat(fb[b*FW +: FW], b == NF-1);
      chk("t2_in_ready_low", 64'(in_ready), 64'(0));
      idle(3);
      chk("t2_a_held_valid", 64'(out_valid), 64'(1));
      chk("t2_a_held_data", 64'(out_features), 64'(fa));
      out_ready = 1;
      idle(1);
      chk("t2_b_no_bubble", 64'(out_valid), 64'(1));
      chk("t2_b_data", 64'(out_features), 64'(fb));
      chk("t2_in_ready_back", 64'(in_ready), 64'(1));
      idle(2);
      chk("t2_drained", 64'(out_valid), 64'(0));
      chk("t2_count", 64'(frame_count), 64'(exp_cnt & 16'hFFFF));

      // T5: reset with a pending output and a partial frame
      out_ready = 0;
      fa = {$urandom, $urandom};
      for (int b = 0; b < NF; b++) beat(fa[b*FW +: FW], b == NF-1);
      for (int b = 0; b < 4; b++) beat(8'($urandom), 1'b0);
      #2 rst = 1; exp_cnt = 0;
      #1;
      chk("t5_in_ready", 64'(in_ready), 64'(1));
      chk("t5_out_valid", 64'(out_valid), 64'(0));
      chk("t5_out_features", 64'(out_features), 64'(0));
      chk("t5_frame_count", 64'(frame_count), 64'(0));
      idle(1); rst = 0; out_ready = 1; idle(1);
      h0 = hs_cnt; e0 = err_cnt;
      fy = {$urandom, $urandom};
      sb_q.push_back(fy);
      for (int b = 0; b < NF; b++) beat(fy[b*FW +: FW], b == NF-1);
      idle(3);
      chk("t5_frame_out", 64'(hs_cnt - h0), 64'(1));
      chk("t5_no_err", 64'(err_cnt - e0), 64'(0));
      chk("t5_count", 64'(frame_count), 64'(1));
      chk("main_sb_empty", 64'(sb_q.size()), 64'(0));
   endtask

   task automatic wrap_test();
      int sent = 0;
      int n = 0;
      w_in_valid = 0; w_in_data = '0; w_in_last = 1; w_out_ready = 1;
      idle(3); w_rst = 0;
      while (sent < 65536) begin
         @(posedge clk); #1;
         w_in_valid = ($urandom_range(31) != 0);
         w_in_data  = 8'($urandom);
         @(negedge clk);
         if (w_in_valid && w_in_ready) begin
            wsb_q.push_back(w_in_data);
            sent++;
         end
      end
      @(posedge clk); #1;
      w_in_valid = 0;
      while (w_hs < 65536 && n < 100) begin @(posedge clk); n++; end
      #1;
      chk("wrap_handshakes", 64'(w_hs), 64'(65536));
      chk("wrap_count_zero", 64'(w_frame_count), 64'(0));
      chk("wrap_no_err", 64'(w_err), 64'(0));
      chk("wrap_sb_empty", 64'(wsb_q.size()), 64'(0));
   endtask

   initial begin
      rst = 1; w_rst = 1;
      in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
      w_in_valid = 0; w_in_data = '0; w_in_last = 1; w_out_ready = 1;
      fork
         main_test();
         wrap_test();
      join
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
